// File: rtl/z16_pkg.sv
// z16_pkg -- shared definitions for the Z16 fetch path.
//   XLEN            : instruction and address width
//   PC_INC          : byte increment between sequential instruction words
//   HALT_INSTR_DEF  : default halt encoding (JRL 0 ZR G11)
//   fetch_state_e   : fetch FSM state type
package z16_pkg;
   localparam int          XLEN           = 16;
   localparam logic [15:0] PC_INC         = 16'd2;
   localparam logic [15:0] HALT_INSTR_DEF = 16'h00FD;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_e;
endpackage

// File: rtl/z16_pc_reg.sv
// z16_pc_reg -- program counter register.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_load          : load i_target (highest priority)
//   i_target        : byte address to load; bit 0 is discarded
//   i_hold          : keep the current PC when not loading
//   o_pc            : current PC, bit 0 always zero
module z16_pc_reg
   import z16_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_load,
   input  logic [XLEN-1:0] i_target,
   input  logic            i_hold,
   output logic [XLEN-1:0] o_pc
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (i_load) begin
         pc_d = {i_target[XLEN-1:1], 1'b0};
      end else if (!i_hold) begin
         // 16-bit add wraps 16'hFFFE to 16'h0000 naturally.
         pc_d = pc_q + PC_INC;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_q <= {RESET_PC[XLEN-1:1], 1'b0};
      end else begin
         pc_q <= pc_d;
      end
   end

   assign o_pc = pc_q;

endmodule

// File: rtl/z16_fetch_unit.sv
// z16_fetch_unit -- single-issue instruction fetch with halt detection.
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_stall                : downstream not ready; freeze everything
//   i_redirect/_pc         : taken branch/jump; reload PC, drop held instruction
//   o_imem_addr            : byte address to instruction memory (= PC)
//   i_imem_instr           : combinational memory read data
//   o_instr/o_instr_pc     : registered instruction and its fetch address
//   o_valid                : o_instr is live
//   o_halted               : fetch stopped on the halt encoding
module z16_fetch_unit
   import z16_pkg::*;
#(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] HALT_INSTR = HALT_INSTR_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_stall,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic [XLEN-1:0] i_imem_instr,
   output logic [XLEN-1:0] o_instr,
   output logic [XLEN-1:0] o_instr_pc,
   output logic            o_valid,
   output logic            o_halted
);

   fetch_state_e    state_q;
   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] instr_pc_q;
   logic            valid_q;
   logic [XLEN-1:0] pc;
   logic            is_halt_word;
   logic            pc_hold;

   assign is_halt_word = (i_imem_instr == HALT_INSTR);
   // PC advances only on a RUN-state fetch of a non-halt word; the halt
   // word itself leaves PC pointing at it.
   assign pc_hold = i_stall || (state_q == ST_HALT) || is_halt_word;

   z16_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_load   (i_redirect),
      .i_target (i_redirect_pc),
      .i_hold   (pc_hold),
      .o_pc     (pc)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_RUN;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
      end else if (i_redirect) begin
         // Instruction register keeps its stale contents, marked invalid.
         state_q <= ST_RUN;
         valid_q <= 1'b0;
      end else if (!i_stall) begin
         case (state_q)
            ST_RUN: begin
               instr_q    <= i_imem_instr;
               instr_pc_q <= pc;
               valid_q    <= 1'b1;
               if (is_halt_word) begin
                  state_q <= ST_HALT;
               end
            end
            ST_HALT: begin
               valid_q <= 1'b0;
            end
            default: begin
               state_q <= ST_RUN;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_imem_addr = pc;
   assign o_instr     = instr_q;
   assign o_instr_pc  = instr_pc_q;
   assign o_valid     = valid_q;
   assign o_halted    = (state_q == ST_HALT);

endmodule
